axi4_slave_mem: RTL and testbench



---
 rtl/axi4_pkg.sv | 21 ++
 rtl/axi4_slave_mem_if.sv | 83 ++++++++
 rtl/axi4_slave_ram.sv | 36 +++
 rtl/axi4_slave_mem.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI codes, FSM state types and response helper for the memory-backed slave.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // Encodings already sort by severity: DECERR > SLVERR > OKAY.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_slave_mem_if.sv
// AW/W/B/AR/R channel bundle between an AXI master and the memory slave.
interface axi4_slave_mem_if #(
  parameter int data_wid = 32,
  parameter int adr_wid  = 32,
  parameter int id_wid   = 4,
  parameter int len_wid  = 4,
  parameter int siz_wid  = 3,
  parameter int bst_wid  = 2,
  parameter int loc_wid  = 2,
  parameter int cach_wid = 2,
  parameter int prot_wid = 3,
  parameter int rsp_wid  = 2
);
  localparam int strb_wid = data_wid / 8;

  logic [id_wid-1:0]   AWID;
  logic [adr_wid-1:0]  AWADDR;
  logic [len_wid-1:0]  AWLEN;
  logic [siz_wid-1:0]  AWSIZE;
  logic [bst_wid-1:0]  AWBURST;
  logic [loc_wid-1:0]  AWLOCK;
  logic [cach_wid-1:0] AWCACHE;
  logic [prot_wid-1:0] AWPROT;
  logic                AWVALID;
  logic                AWREADY;

  logic [id_wid-1:0]   WID;
  logic [data_wid-1:0] WDATA;
  logic [strb_wid-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [id_wid-1:0]   BID;
  logic [rsp_wid-1:0]  BRESP;
  logic                BVALID;
  logic                BREADY;

  logic [id_wid-1:0]   ARID;
  logic [adr_wid-1:0]  ARADDR;
  logic [len_wid-1:0]  ARLEN;
  logic [siz_wid-1:0]  ARSIZE;
  logic [bst_wid-1:0]  ARBURST;
  logic [loc_wid-1:0]  ARLOCK;
  logic [cach_wid-1:0] ARCACHE;
  logic [prot_wid-1:0] ARPROT;
  logic                ARVALID;
  logic                ARREADY;

  logic [id_wid-1:0]   RID;
  logic [data_wid-1:0] RDATA;
  logic [rsp_wid-1:0]  RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi4_slave_ram.sv
// Byte-lane word RAM: one strobed write port, one registered read port (read-before-write).
module axi4_slave_ram #(
  parameter int data_wid  = 32,
  parameter int mem_depth = 256,
  localparam int strb_wid = data_wid / 8,
  localparam int aw       = $clog2(mem_depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [aw-1:0]       waddr_i,
  input  logic [strb_wid-1:0] wstrb_i,
  input  logic [data_wid-1:0] wdata_i,
  input  logic                re_i,
  input  logic [aw-1:0]       raddr_i,
  output logic [data_wid-1:0] rdata_o
);

  for (genvar g = 0; g < strb_wid; g++) begin : g_lane
    logic [7:0] mem [mem_depth];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i && wstrb_i[g]) mem[waddr_i] <= wdata_i[g*8 +: 8];
    end

    // Array contents are deliberately left unreset; only the output register clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   rd_q <= '0;
      else if (re_i) rd_q <= mem[raddr_i];
    end

    assign rdata_o[g*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 (WID-style) memory slave: independent write and read burst engines over a byte-lane RAM.
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int data_wid  = 32,
  parameter int adr_wid   = 32,
  parameter int id_wid    = 4,
  parameter int len_wid   = 4,
  parameter int siz_wid   = 3,
  parameter int bst_wid   = 2,
  parameter int loc_wid   = 2,
  parameter int cach_wid  = 2,
  parameter int prot_wid  = 3,
  parameter int rsp_wid   = 2,
  parameter int mem_depth = 256
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  axi4_slave_mem_if.slave bus
);

  localparam int strb_wid = data_wid / 8;
  localparam int BYTE_W   = $clog2(strb_wid);
  localparam int WORD_W   = $clog2(mem_depth);
  localparam logic [adr_wid-1:0] MEM_BYTES = adr_wid'(mem_depth * strb_wid);
  localparam logic [siz_wid-1:0] MAX_SIZE  = siz_wid'(BYTE_W);

  function automatic logic [adr_wid-1:0] next_addr(input logic [adr_wid-1:0] a,
                                                   input logic [siz_wid-1:0] sz,
                                                   input logic [bst_wid-1:0] bst);
    logic [adr_wid-1:0] inc;
    inc = adr_wid'(1) << sz;
    if (bst == BURST_FIXED) return a;
    return (a & ~(inc - adr_wid'(1))) + inc;
  endfunction

  function automatic logic burst_bad(input logic [bst_wid-1:0] bst, input logic [siz_wid-1:0] sz);
    return (bst == BURST_WRAP) || (bst == 2'b11) || (sz > MAX_SIZE);
  endfunction

  function automatic logic [1:0] beat_resp(input logic berr, input logic [adr_wid-1:0] a);
    return worst_resp(berr ? RESP_SLVERR : RESP_OKAY, (a >= MEM_BYTES) ? RESP_DECERR : RESP_OKAY);
  endfunction

  // Held low through reset and for the first edge after release so both readies start at 0.
  logic ready_en_q;

  wstate_e             w_state_q, w_state_d;
  logic [id_wid-1:0]   w_id_q,    w_id_d;
  logic [adr_wid-1:0]  w_addr_q,  w_addr_d;
  logic [len_wid-1:0]  w_len_q,   w_len_d;
  logic [siz_wid-1:0]  w_size_q,  w_size_d;
  logic [bst_wid-1:0]  w_bst_q,   w_bst_d;
  logic [len_wid-1:0]  w_beat_q,  w_beat_d;
  logic                w_berr_q,  w_berr_d;
  logic [1:0]          w_resp_q,  w_resp_d;
  logic                w_last_beat, w_hs;

  rstate_e             r_state_q, r_state_d;
  logic [id_wid-1:0]   r_id_q,    r_id_d;
  logic [adr_wid-1:0]  r_addr_q,  r_addr_d;
  logic [len_wid-1:0]  r_len_q,   r_len_d;
  logic [siz_wid-1:0]  r_size_q,  r_size_d;
  logic [bst_wid-1:0]  r_bst_q,   r_bst_d;
  logic [len_wid-1:0]  r_beat_q,  r_beat_d;
  logic                r_berr_q,  r_berr_d;
  logic [1:0]          r_resp_q,  r_resp_d;
  logic                r_zero_q,  r_zero_d;
  logic [adr_wid-1:0]  r_addr_nxt;

  logic                ram_we, ram_re;
  logic [WORD_W-1:0]   ram_waddr, ram_raddr;
  logic [data_wid-1:0] ram_rdata;

  axi4_slave_ram #(.data_wid(data_wid), .mem_depth(mem_depth)) u_ram (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wstrb_i (bus.WSTRB),
    .wdata_i (bus.WDATA),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // ---------------- write channel ----------------
  assign w_hs        = (w_state_q == W_DATA) && bus.WVALID;
  assign w_last_beat = (w_beat_q == w_len_q);
  assign ram_waddr   = w_addr_q[BYTE_W +: WORD_W];
  assign ram_we      = w_hs && !w_berr_q && (w_addr_q < MEM_BYTES);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_bst_d   = w_bst_q;
    w_beat_d  = w_beat_q;
    w_berr_d  = w_berr_q;
    w_resp_d  = w_resp_q;
    case (w_state_q)
      W_IDLE: if (bus.AWVALID && ready_en_q) begin
        w_id_d    = bus.AWID;
        w_addr_d  = bus.AWADDR;
        w_len_d   = bus.AWLEN;
        w_size_d  = bus.AWSIZE;
        w_bst_d   = bus.AWBURST;
        w_beat_d  = '0;
        w_berr_d  = burst_bad(bus.AWBURST, bus.AWSIZE);
        w_resp_d  = RESP_OKAY;
        w_state_d = W_DATA;
      end
      W_DATA: if (bus.WVALID) begin
        // Beat count alone ends the burst; a misplaced WLAST only taints the response.
        w_resp_d = worst_resp(w_resp_q,
                   worst_resp(beat_resp(w_berr_q, w_addr_q),
                              (bus.WLAST != w_last_beat) ? RESP_SLVERR : RESP_OKAY));
        w_addr_d = next_addr(w_addr_q, w_size_q, w_bst_q);
        w_beat_d = w_beat_q + len_wid'(1);
        if (w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: if (bus.BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ready_en_q <= 1'b0;
      w_state_q  <= W_IDLE;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_size_q   <= '0;
      w_bst_q    <= '0;
      w_beat_q   <= '0;
      w_berr_q   <= 1'b0;
      w_resp_q   <= RESP_OKAY;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_size_q   <= w_size_d;
      w_bst_q    <= w_bst_d;
      w_beat_q   <= w_beat_d;
      w_berr_q   <= w_berr_d;
      w_resp_q   <= w_resp_d;
    end
  end

  assign bus.AWREADY = ready_en_q && (w_state_q == W_IDLE);
  assign bus.WREADY  = (w_state_q == W_DATA);
  assign bus.BVALID  = (w_state_q == W_RESP);
  assign bus.BID     = w_id_q;
  assign bus.BRESP   = rsp_wid'(w_resp_q);

  // ---------------- read channel ----------------
  // The RAM is read one cycle ahead: on AR accept and on every non-final R handshake.
  assign r_addr_nxt = next_addr(r_addr_q, r_size_q, r_bst_q);

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_bst_d   = r_bst_q;
    r_beat_d  = r_beat_q;
    r_berr_d  = r_berr_q;
    r_resp_d  = r_resp_q;
    r_zero_d  = r_zero_q;
    ram_re    = 1'b0;
    ram_raddr = r_addr_q[BYTE_W +: WORD_W];
    case (r_state_q)
      R_IDLE: if (bus.ARVALID && ready_en_q) begin
        r_id_d    = bus.ARID;
        r_addr_d  = bus.ARADDR;
        r_len_d   = bus.ARLEN;
        r_size_d  = bus.ARSIZE;
        r_bst_d   = bus.ARBURST;
        r_beat_d  = '0;
        r_berr_d  = burst_bad(bus.ARBURST, bus.ARSIZE);
        r_resp_d  = beat_resp(r_berr_d, bus.ARADDR);
        r_zero_d  = (r_resp_d != RESP_OKAY);
        ram_re    = 1'b1;
        ram_raddr = bus.ARADDR[BYTE_W +: WORD_W];
        r_state_d = R_DATA;
      end
      R_DATA: if (bus.RREADY) begin
        if (r_beat_q == r_len_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_addr_d  = r_addr_nxt;
          r_beat_d  = r_beat_q + len_wid'(1);
          r_resp_d  = beat_resp(r_berr_q, r_addr_nxt);
          r_zero_d  = (r_resp_d != RESP_OKAY);
          ram_re    = 1'b1;
          ram_raddr = r_addr_nxt[BYTE_W +: WORD_W];
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_bst_q   <= '0;
      r_beat_q  <= '0;
      r_berr_q  <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      r_zero_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_bst_q   <= r_bst_d;
      r_beat_q  <= r_beat_d;
      r_berr_q  <= r_berr_d;
      r_resp_q  <= r_resp_d;
      r_zero_q  <= r_zero_d;
    end
  end

  assign bus.ARREADY = ready_en_q && (r_state_q == R_IDLE);
  assign bus.RVALID  = (r_state_q == R_DATA);
  assign bus.RID     = r_id_q;
  assign bus.RRESP   = rsp_wid'(r_resp_q);
  assign bus.RLAST   = (r_state_q == R_DATA) && (r_beat_q == r_len_q);
  assign bus.RDATA   = r_zero_q ? '0 : ram_rdata;

  // Lock/cache/prot and WID carry no meaning for this target.
  logic unused_ok;
  assign unused_ok = ^{bus.AWLOCK, bus.AWCACHE, bus.AWPROT, bus.WID,
                       bus.ARLOCK, bus.ARCACHE, bus.ARPROT};

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Randomized bench for axi4_slave_mem against a byte-array reference memory.
module tb_axi4_slave_mem;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi4_slave_mem_if bus ();
  axi4_slave_mem dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0]  mref [0:1023];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Beat i address: first beat as issued, later beats step from the size-aligned start.
  function automatic logic [31:0] bt_addr(input logic [31:0] a, input int i,
                                          input logic [2:0] sz, input logic [1:0] bst);
    logic [31:0] n;
    n = 32'd1 << sz;
    if (bst == 2'b00 || i == 0) return a;
    return (a / n) * n + 32'(i) * n;
  endfunction

  function automatic bit bad(input logic [1:0] bst, input logic [2:0] sz);
    return (bst >= 2'd2) || (sz > 3'd2);
  endfunction

  function automatic logic [1:0] maxr(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    int base;
    base = int'(a[9:2]) * 4;
    return {mref[base+3], mref[base+2], mref[base+1], mref[base]};
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] sz, input logic [1:0] bst, input int lastb, input int bdly);
    logic [1:0]  er;
    logic [31:0] a;
    int t;
    er = bad(bst, sz) ? 2'd2 : 2'd0;
    for (int i = 0; i <= int'(len); i++) begin
      a = bt_addr(addr, i, sz, bst);
      if (a >= 32'd1024) er = maxr(er, 2'd3);
      if ((i == lastb) != (i == int'(len))) er = maxr(er, 2'd2);
    end
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = sz; bus.AWBURST = bst;
    bus.AWLOCK = 2'($urandom); bus.AWCACHE = 2'($urandom); bus.AWPROT = 3'($urandom);
    bus.AWVALID = 1'b1;
    t = 0;
    while (bus.AWREADY !== 1'b1 && t < 50) begin @(posedge ACLK); #1; t++; end
    chk("aw_wait", 64'(t < 50), 64'd1);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    chk("w_ready", bus.WREADY, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge ACLK); #1; end
      bus.WVALID = 1'b1; bus.WDATA = wdat[i]; bus.WSTRB = wstb[i];
      bus.WLAST = (i == lastb); bus.WID = id;
      t = 0;
      while (bus.WREADY !== 1'b1 && t < 20) begin @(posedge ACLK); #1; t++; end
      chk("w_wait", 64'(t < 20), 64'd1);
      @(posedge ACLK); #1;
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    end
    if (!bad(bst, sz))
      for (int i = 0; i <= int'(len); i++) begin
        a = bt_addr(addr, i, sz, bst);
        if (a < 32'd1024)
          for (int b = 0; b < 4; b++)
            if (wstb[i][b]) mref[int'(a[9:2]) * 4 + b] = wdat[i][8*b +: 8];
      end
    chk("b_valid", bus.BVALID, 1'b1);
    chk("b_id", bus.BID, id);
    chk("b_resp", bus.BRESP, er);
    repeat (bdly) begin
      @(posedge ACLK); #1;
      chk("b_hold", bus.BVALID, 1'b1);
      chk("b_resp_hold", bus.BRESP, er);
      chk("aw_low", bus.AWREADY, 1'b0);
    end
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    chk("b_done", bus.BVALID, 1'b0);
    chk("aw_back", bus.AWREADY, 1'b1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bst, input int stall0, input int srnd);
    logic [31:0] a, ed;
    logic [1:0]  er;
    bit o, bb;
    int t, s;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = sz; bus.ARBURST = bst;
    bus.ARLOCK = 2'($urandom); bus.ARCACHE = 2'($urandom); bus.ARPROT = 3'($urandom);
    bus.ARVALID = 1'b1;
    t = 0;
    while (bus.ARREADY !== 1'b1 && t < 50) begin @(posedge ACLK); #1; t++; end
    chk("ar_wait", 64'(t < 50), 64'd1);
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    chk("r_first", bus.RVALID, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      a  = bt_addr(addr, i, sz, bst);
      bb = bad(bst, sz);
      o  = (a >= 32'd1024);
      ed = (bb || o) ? 32'h0 : mword(a);
      er = maxr(bb ? 2'd2 : 2'd0, o ? 2'd3 : 2'd0);
      t = 0;
      while (bus.RVALID !== 1'b1 && t < 20) begin @(posedge ACLK); #1; t++; end
      chk("r_wait", 64'(t < 20), 64'd1);
      chk("r_data", bus.RDATA, ed);
      chk("r_resp", bus.RRESP, er);
      chk("r_last", bus.RLAST, 64'(i == int'(len)));
      chk("r_id", bus.RID, id);
      s = (i == 0) ? stall0 : int'($urandom_range(0, srnd));
      if (s > 0) begin
        bus.RREADY = 1'b0;
        repeat (s) begin
          @(posedge ACLK); #1;
          chk("r_hold_v", bus.RVALID, 1'b1);
          chk("r_hold_d", bus.RDATA, ed);
          chk("r_hold_l", bus.RLAST, 64'(i == int'(len)));
        end
      end
      bus.RREADY = 1'b1;
      @(posedge ACLK); #1;
    end
    bus.RREADY = 1'b0;
    chk("r_done", bus.RVALID, 1'b0);
    chk("ar_back", bus.ARREADY, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  id, len;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [1:0]  bst;
    int r, lastb;

    {bus.AWID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST, bus.AWLOCK, bus.AWCACHE, bus.AWPROT} = '0;
    {bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.ARLOCK, bus.ARCACHE, bus.ARPROT} = '0;
    {bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.ARVALID, bus.RREADY} = '0;
    bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0;

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", bus.AWREADY, 1'b0);
    chk("rst_arready", bus.ARREADY, 1'b0);
    chk("rst_wready", bus.WREADY, 1'b0);
    chk("rst_bvalid", bus.BVALID, 1'b0);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_rdata", bus.RDATA, 32'h0);
    chk("rst_rlast", bus.RLAST, 1'b0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("rel_awready", bus.AWREADY, 1'b1);
    chk("rel_arready", bus.ARREADY, 1'b1);

    // Fill the whole RAM so every later read has a known expectation
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      do_write(4'(k), 32'(k * 64), 4'd15, 3'd2, 2'b01, 15, 0);
    end

    // INCR burst write then read back
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    do_write(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 3, 0);
    do_read(4'd6, 32'h10, 4'd3, 3'd2, 2'b01, 0, 0);

    // Partial strobe merge
    wdat[0] = 32'h12345678; wstb[0] = 4'hF;
    do_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 0, 0);
    wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'h3;
    do_write(4'd2, 32'h40, 4'd0, 3'd2, 2'b01, 0, 1);
    do_read(4'd3, 32'h40, 4'd0, 3'd2, 2'b01, 0, 0);

    // FIXED read with a long RREADY stall on the first beat
    do_read(4'd7, 32'h10, 4'd2, 3'd2, 2'b00, 5, 0);

    // Out-of-range write must not alias word 0; WRAP read is a whole-burst error
    wdat[0] = $urandom; wstb[0] = 4'hF;
    do_write(4'd8, 32'h400, 4'd0, 3'd2, 2'b01, 0, 0);
    do_read(4'd9, 32'h0, 4'd0, 3'd2, 2'b01, 0, 0);
    do_read(4'd10, 32'h20, 4'd3, 3'd2, 2'b10, 0, 1);

    // Early WLAST, response held against BREADY
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(4'd11, 32'h80, 4'd3, 3'd2, 2'b01, 1, 3);
    do_read(4'd12, 32'h80, 4'd3, 3'd2, 2'b01, 0, 0);

    // Write and read bursts running at the same time on disjoint regions
    for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
    fork
      do_write(4'd3, 32'h200, 4'd7, 3'd2, 2'b01, 7, 1);
      do_read(4'd9, 32'h300, 4'd7, 3'd2, 2'b01, 0, 1);
    join
    do_read(4'd4, 32'h200, 4'd7, 3'd2, 2'b01, 0, 0);

    // Reset in the middle of a read burst
    bus.ARID = 4'd1; bus.ARADDR = 32'h80; bus.ARLEN = 4'd7; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01;
    bus.ARVALID = 1'b1;
    chk("mid_arready", bus.ARREADY, 1'b1);
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    repeat (2) begin @(posedge ACLK); #1; end
    chk("mid_rvalid", bus.RVALID, 1'b1);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.RVALID, 1'b0);
    chk("mid_rst_rdata", bus.RDATA, 32'h0);
    chk("mid_rst_rlast", bus.RLAST, 1'b0);
    bus.RREADY = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    chk("mid_rel_arready0", bus.ARREADY, 1'b0);
    @(posedge ACLK); #1;
    chk("mid_rel_arready1", bus.ARREADY, 1'b1);
    chk("mid_rel_awready1", bus.AWREADY, 1'b1);

    // Randomized bursts, each written then read back
    for (int it = 0; it < 30; it++) begin
      id   = 4'($urandom);
      len  = 4'($urandom_range(0, 15));
      sz   = 3'($urandom_range(0, 2));
      bst  = 2'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 1023));
      r    = int'($urandom_range(0, 9));
      if (r == 0) addr = 32'($urandom_range(900, 1300));
      if (r == 1) begin bst = 2'($urandom_range(2, 3)); addr = 32'($urandom_range(0, 255)); len = 4'($urandom_range(0, 3)); end
      if (r == 2) begin sz = 3'($urandom_range(3, 7)); addr = 32'($urandom_range(0, 255)); len = 4'($urandom_range(0, 3)); end
      lastb = (r == 3) ? int'($urandom_range(0, 15)) : int'(len);
      for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      do_write(id, addr, len, sz, bst, lastb, int'($urandom_range(0, 2)));
      do_read(4'(id + 1), addr, len, sz, bst, int'($urandom_range(0, 2)), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
